// File: rtl/nibble_add_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE_W : width of one adder slice (the cla slice width)
//   state_e  : control state encoding (IDLE, RUN, DONE)
package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : nibble_add_pkg

// File: rtl/cla.sv
// 4-bit carry-lookahead adder slice, purely combinational.
//   a, b : 4-bit addends
//   cin  : carry-in
//   sum  : 4-bit sum
//   cout : carry-out
module cla (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat sum of generate/propagate terms, so no carry
  // depends on the carry of the bit below it.
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ c;

endmodule : cla

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that reuses one 4-bit cla slice over WIDTH/4 clocks,
// least-significant nibble first, with the inter-nibble carry registered.
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   start : request a new addition, honoured only when busy is low
//   a, b  : WIDTH-bit operands, captured on the accepting edge
//   cin   : carry-in, captured on the accepting edge
//   busy  : high while the nibble loop runs
//   done  : one-cycle pulse when sum/cout hold a new result
//   sum   : registered sum, held until the next completion
//   cout  : registered carry-out of the most significant nibble
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N     = WIDTH / NIBBLE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q,   idx_d;
  logic [WIDTH-1:0]      a_q,     a_d;
  logic [WIDTH-1:0]      b_q,     b_d;
  logic                  carry_q, carry_d;
  logic [WIDTH-1:0]      res_q,   res_d;
  logic [WIDTH-1:0]      sum_q,   sum_d;
  logic                  cout_q,  cout_d;

  logic [NIBBLE_W-1:0]   a_nib, b_nib, slice_sum;
  logic                  slice_cout;

  // Operand nibble mux selected by the running index.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // through the block leaves it unassigned (which would infer a latch).
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  cla u_cla (
    .a    (a_nib),
    .b    (b_nib),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      ST_RUN: begin
        for (int i = 0; i < N; i++) begin
          if (idx_q == IDX_W'(i)) res_d[i*NIBBLE_W +: NIBBLE_W] = slice_sum;
        end
        carry_d = slice_cout;
        idx_d   = idx_q + 1'b1;
        // Last nibble: publish res_d (which already includes this nibble).
        if (idx_q == LAST_IDX) begin
          sum_d   = res_d;
          cout_d  = slice_cout;
          state_d = ST_DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
        state_d = ST_IDLE;
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the operand/result registers are plain flops, not a memory
    // array, so clearing them in reset is cheap and keeps sum at zero.
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule : nibble_serial_adder

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int N     = WIDTH / 4;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int checks;
  int errors;

  // Reference state: last published result.
  logic [WIDTH-1:0] model_sum;
  logic             model_cout;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one rising edge; return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present an operation at the current falling edge (accepted on the next
  // rising edge) and check the whole busy window plus the done cycle.
  // Returns in the DONE cycle so the caller can chain a back-to-back op.
  task automatic run_op(input string name, input logic [WIDTH-1:0] op_a,
                        input logic [WIDTH-1:0] op_b, input logic op_cin,
                        input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    start = 1'b1;
    a     = op_a;
    b     = op_b;
    cin   = op_cin;
    step();
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    for (int i = 0; i < N; i++) begin
      check({name, " busy"}, busy, 1);
      check({name, " no done"}, done, 0);
      check({name, " sum held"}, sum, model_sum);
      step();
    end
    model_sum  = exp_sum;
    model_cout = exp_cout;
    check({name, " done"}, done, 1);
    check({name, " busy low"}, busy, 0);
    check({name, " sum"}, sum, exp_sum);
    check({name, " cout"}, cout, exp_cout);
  endtask

  task automatic go_idle(input string name);
    step();
    check({name, " idle done"}, done, 0);
    check({name, " idle busy"}, busy, 0);
    check({name, " idle sum"}, sum, model_sum);
  endtask

  vec_t vecs[5];

  initial begin
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] ra, rb;
    logic             rc;
    int               done_seen;

    checks = 0;
    errors = 0;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[4] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    model_sum  = '0;
    model_cout = 1'b0;

    // Reset for two edges.
    @(negedge clk);
    step();
    step();
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    rst_n = 1'b1;
    go_idle("post reset");

    // Table-driven directed vectors.
    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].exp_sum, vecs[i].exp_cout);
      go_idle($sformatf("vec%0d", i));
    end

    // start during RUN is ignored: 1+1 with a second request mid-loop.
    start = 1'b1; a = 16'h0001; b = 16'h0001; cin = 1'b0;
    step();
    start = 1'b0;
    step();
    start = 1'b1; a = 16'hAAAA;
    step();
    start = 1'b0;
    step();
    check("ignore still busy", busy, 1);
    check("ignore no early done", done, 0);
    step();
    check("ignore done", done, 1);
    check("ignore sum", sum, 16'h0002);
    check("ignore cout", cout, 0);
    model_sum = 16'h0002; model_cout = 1'b0;
    step();
    check("ignore single done", done, 0);
    check("ignore idle busy", busy, 0);

    // Reset in the second RUN cycle aborts without done.
    start = 1'b1; a = 16'h00FF; b = 16'h0001; cin = 1'b0;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_sum = '0; model_cout = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort sum", sum, 0);
    check("abort cout", cout, 0);
    done_seen = 0;
    for (int i = 0; i < N + 2; i++) begin
      if (done) done_seen++;
      step();
    end
    check("abort never done", done_seen, 0);
    run_op("after abort", 16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0);

    // Back-to-back: new start in the DONE cycle.
    run_op("b2b", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    go_idle("b2b");

    // Randomized operations against the arithmetic model.
    for (int t = 0; t < 40; t++) begin
      ra   = WIDTH'($urandom);
      rb   = WIDTH'($urandom);
      rc   = 1'($urandom);
      if (t % 5 == 0) ra = '1;
      full = {1'b0, ra} + {1'b0, rb} + {{WIDTH{1'b0}}, rc};
      run_op($sformatf("rand%0d", t), ra, rb, rc, full[WIDTH-1:0], full[WIDTH]);
      if ($urandom_range(1, 0) == 1) go_idle($sformatf("rand%0d", t));
    end
    go_idle("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule : tb_nibble_serial_adder
